ex_1ri20_unit: RTL and testbench
================================

Name: ex_1ri20_unit

Overview:
- Execute-stage consumer for 1RI20-format instructions (LU12I.W, PCADDU12I) after they leave the decoder.
- Accepts the decoded bundle over a valid/ready handshake and computes the 32-bit result.
- Folds in illegal-instruction detection, then queues the writeback packet in a small FIFO toward the writeback/commit stage.
- Sits between the ID issue point and the WB/commit port; also provides a retired-packet counter for the perf CSRs.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2).
- CNT_W, 32, width of the retired-packet counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush, synchronous, single cycle.
- id_valid  in  1  decoded bundle valid.
- id_ready  out  1  unit can accept a bundle this cycle.
- id_pc  in  32  instruction PC.
- id_inst  in  32  raw instruction word.
- id_inst_valid  in  1  decoder recognised the opcode.
- id_aluop  in  8  `ALU_LU12I / `ALU_PCADDU12I / other.
- id_imm  in  32  {si20,12'b0} from decode.
- id_reg_write_en  in  1  decoder write enable.
- id_reg_write_addr  in  5  rd.
- id_is_exception  in  3  per-stage exception flags (bit0 IF, bit1 ID, bit2 EX).
- id_exception_cause  in  21  3×7-bit causes, slot i at [7i+6:7i].
- wb_valid  out  1  head packet valid.
- wb_ready  in  1  consumer takes the head packet.
- wb_pc  out  32  packet PC.
- wb_inst  out  32  packet instruction.
- wb_result  out  32  computed result.
- wb_reg_write_en  out  1  final write enable.
- wb_reg_write_addr  out  5  destination register.
- wb_is_exception  out  3  exception flags.
- wb_exception_cause  out  21  exception causes.
- retired_cnt  out  CNT_W  count of completed wb handshakes.

Behaviour:
- Reset (rst_n=0, async): FIFO empty, count=0, wb_valid=0, every wb_* payload output 0, retired_cnt=0. id_ready reads 1 once rst_n is deasserted.
- id_ready = (count < DEPTH). It depends only on registered state; there is no combinational path from wb_ready.
- Push when id_valid & id_ready. Pop when wb_valid & wb_ready.
  - Push and pop in the same cycle: count is unchanged, and both pointers advance modulo DEPTH.
  - Push while full cannot occur because id_ready=0.
- Latency: a bundle accepted on edge N appears at the head, with wb_valid=1, after edge N, provided the FIFO was empty. The result is computed combinationally before the write into the FIFO.
- Result computation:
  - aluop=`ALU_LU12I: result = id_imm.
  - aluop=`ALU_PCADDU12I: result = id_pc + id_imm, 32-bit modulo, carry dropped.
  - Any other aluop: result = 0.
- Exception folding:
  - If id_inst_valid=0 and id_is_exception==0: set flag bit1 and put `EXCEPTION_INE in cause slot 1; other slots pass through.
  - Otherwise flags and causes pass through unchanged.
- Final write enable = id_reg_write_en & (flags==0) & (id_reg_write_addr != 0). Writes to r0 are suppressed; the result is still carried.
- FIFO is full for DEPTH entries: wb payload stays stable while wb_valid=1 and wb_ready=0.
- retired_cnt increments by 1 on every pop, including excepting packets, and wraps to 0 at 2^CNT_W.
- flush=1 at a clock edge:
  - Pointers and count are cleared; wb_valid=0 in the next cycle.
  - A push or pop presented in that same cycle is discarded: no entry is written and the counter does not increment.
  - id_ready=1 in the following cycle.
- Reset mid-operation discards all entries immediately and asynchronously; retired_cnt returns to 0.

Decomposition:
- ALU op codes, `EXCEPTION_INE and the exception slot indices stay in the shared defines header already used by decode.
- Add a localparam/define for exception slot bit positions (IF=0, ID=1, EX=2) there.
- One natural sub-module: ex_wb_fifo. It is a generic DEPTH×W synchronous FIFO with async active-low reset, flush, push/pop, full/empty/count.
- The top level holds the result/exception logic and the counter.

Test Plan:
- LU12I: id_pc=0x1C000000, imm=0x12345000, rd=4, wb_ready=1 → next cycle wb_result=0x12345000, wb_reg_write_en=1, addr=4, retired_cnt=1.
- PCADDU12I wrap: pc=0xFFFFF000, imm=0x00002000 → wb_result=0x00001000. Separately, pc=0x1C000004, imm=0x00001000 → wb_result=0x1C001004.
- Backpressure: wb_ready=0, push 3 back-to-back bundles → first two accepted, id_ready=0 on the third cycle, third held by source. Raise wb_ready → packets emerge in order, head payload stable while stalled.
- Illegal instruction: inst_valid=0, aluop=`ALU_NOP, write_en=0 → wb_is_exception=3'b010, cause slot1=`EXCEPTION_INE, wb_reg_write_en=0, wb_result=0. With rd=0 and a legal LU12I → wb_reg_write_en=0.
- Flush: FIFO holds 2 entries, assert flush together with id_valid=1 and wb_ready=1 → next cycle wb_valid=0, id_ready=1, retired_cnt unchanged.
- Reset mid-stream: rst_n low asynchronously between edges with 1 entry queued → wb_valid=0 and retired_cnt=0 immediately. After release, a fresh LU12I completes normally.

Source files
------------

// File: rtl/ex_1ri20_unit_pkg.sv
// Shared decode/execute definitions for the 1RI20 execute unit: ALU op codes,
// exception cause codes and slot positions, and the writeback packet layout.
package ex_1ri20_unit_pkg;

  localparam logic [7:0] ALU_NOP       = 8'h00;
  localparam logic [7:0] ALU_LU12I     = 8'h1A;
  localparam logic [7:0] ALU_PCADDU12I = 8'h1B;

  localparam int         EXC_CAUSE_W   = 7;
  localparam logic [6:0] EXCEPTION_INE = 7'h0D;

  // Bit position of each pipeline stage in the exception flag vector; cause
  // slot i occupies bits [EXC_CAUSE_W*i +: EXC_CAUSE_W].
  localparam int EXC_SLOT_IF = 0;
  localparam int EXC_SLOT_ID = 1;
  localparam int EXC_SLOT_EX = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [2:0]  is_exception;
    logic [20:0] exception_cause;
  } wb_pkt_t;

  function automatic logic [31:0] calc_result(input logic [7:0]  aluop,
                                              input logic [31:0] pc,
                                              input logic [31:0] imm);
    unique case (aluop)
      ALU_LU12I:     return imm;
      ALU_PCADDU12I: return pc + imm;
      default:       return '0;
    endcase
  endfunction

endpackage

// File: rtl/ex_wb_fifo.sv
// Generic DEPTH x W synchronous FIFO with async active-low reset and a
// synchronous flush that drops the contents and any same-cycle push/pop.
module ex_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign rdata  = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // NOTE: the storage is reset as well because the head entry drives the
      // payload outputs directly and must read as zero out of reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ex_1ri20_unit.sv
// Execute stage for LU12I.W / PCADDU12I: computes the result, folds in the
// illegal-instruction exception and queues the packet toward writeback.
module ex_1ri20_unit
  import ex_1ri20_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_inst,
  input  logic             id_inst_valid,
  input  logic [7:0]       id_aluop,
  input  logic [31:0]      id_imm,
  input  logic             id_reg_write_en,
  input  logic [4:0]       id_reg_write_addr,
  input  logic [2:0]       id_is_exception,
  input  logic [20:0]      id_exception_cause,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_inst,
  output logic [31:0]      wb_result,
  output logic             wb_reg_write_en,
  output logic [4:0]       wb_reg_write_addr,
  output logic [2:0]       wb_is_exception,
  output logic [20:0]      wb_exception_cause,
  output logic [CNT_W-1:0] retired_cnt
);

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_flags;
  logic [20:0]      w_cause;
  wb_pkt_t          w_in_pkt;
  wb_pkt_t          w_head_pkt;
  logic [CNT_W-1:0] r_retired_cnt;

  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_flags = id_is_exception;
    w_cause = id_exception_cause;
    if (!id_inst_valid && (id_is_exception == '0)) begin
      w_flags[EXC_SLOT_ID]                               = 1'b1;
      w_cause[EXC_SLOT_ID*EXC_CAUSE_W +: EXC_CAUSE_W] = EXCEPTION_INE;
    end
  end

  assign w_in_pkt = '{
    pc:              id_pc,
    inst:            id_inst,
    result:          calc_result(id_aluop, id_pc, id_imm),
    reg_write_en:    id_reg_write_en & (w_flags == '0) & (id_reg_write_addr != '0),
    reg_write_addr:  id_reg_write_addr,
    is_exception:    w_flags,
    exception_cause: w_cause
  };

  assign id_ready = ~w_full;
  assign wb_valid = ~w_empty;
  assign w_push   = id_valid & id_ready;
  assign w_pop    = wb_valid & wb_ready;

  ex_wb_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(wb_pkt_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (w_push),
    .wdata (w_in_pkt),
    .pop   (w_pop),
    .rdata (w_head_pkt),
    .full  (w_full),
    .empty (w_empty)
  );

  // A pop coinciding with flush is discarded by the FIFO, so it is not retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_retired_cnt <= '0;
    else if (w_pop && !flush)  r_retired_cnt <= r_retired_cnt + 1'b1;
  end

  assign retired_cnt        = r_retired_cnt;
  assign wb_pc              = w_head_pkt.pc;
  assign wb_inst            = w_head_pkt.inst;
  assign wb_result          = w_head_pkt.result;
  assign wb_reg_write_en    = w_head_pkt.reg_write_en;
  assign wb_reg_write_addr  = w_head_pkt.reg_write_addr;
  assign wb_is_exception    = w_head_pkt.is_exception;
  assign wb_exception_cause = w_head_pkt.exception_cause;

endmodule

// File: tb/tb_ex_1ri20_unit.sv
// Directed bench for ex_1ri20_unit: expected packets are queued on acceptance
// and compared against the FIFO head every cycle, popped on a wb handshake.
module tb_ex_1ri20_unit;
  import ex_1ri20_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;
  logic             id_inst_valid;
  logic [7:0]       id_aluop;
  logic [31:0]      id_imm;
  logic             id_reg_write_en;
  logic [4:0]       id_reg_write_addr;
  logic [2:0]       id_is_exception;
  logic [20:0]      id_exception_cause;
  logic             wb_valid;
  logic             wb_ready;
  logic [31:0]      wb_pc;
  logic [31:0]      wb_inst;
  logic [31:0]      wb_result;
  logic             wb_reg_write_en;
  logic [4:0]       wb_reg_write_addr;
  logic [2:0]       wb_is_exception;
  logic [20:0]      wb_exception_cause;
  logic [CNT_W-1:0] retired_cnt;

  wb_pkt_t          q[$];
  logic [CNT_W-1:0] exp_retired;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  ex_1ri20_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (flush),
    .id_valid           (id_valid),
    .id_ready           (id_ready),
    .id_pc              (id_pc),
    .id_inst            (id_inst),
    .id_inst_valid      (id_inst_valid),
    .id_aluop           (id_aluop),
    .id_imm             (id_imm),
    .id_reg_write_en    (id_reg_write_en),
    .id_reg_write_addr  (id_reg_write_addr),
    .id_is_exception    (id_is_exception),
    .id_exception_cause (id_exception_cause),
    .wb_valid           (wb_valid),
    .wb_ready           (wb_ready),
    .wb_pc              (wb_pc),
    .wb_inst            (wb_inst),
    .wb_result          (wb_result),
    .wb_reg_write_en    (wb_reg_write_en),
    .wb_reg_write_addr  (wb_reg_write_addr),
    .wb_is_exception    (wb_is_exception),
    .wb_exception_cause (wb_exception_cause),
    .retired_cnt        (retired_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of the packet the unit should produce for the driven bundle.
  function automatic wb_pkt_t model();
    wb_pkt_t p;
    logic [2:0]  flags = id_is_exception;
    logic [20:0] cause = id_exception_cause;
    if (!id_inst_valid && id_is_exception == 3'b000) begin
      flags       = 3'b010;
      cause[13:7] = EXCEPTION_INE;
    end
    p.pc              = id_pc;
    p.inst            = id_inst;
    if (id_aluop == ALU_LU12I)          p.result = id_imm;
    else if (id_aluop == ALU_PCADDU12I) p.result = id_pc + id_imm;
    else                                p.result = 32'h0;
    p.reg_write_en    = id_reg_write_en && flags == 3'b000 && id_reg_write_addr != 5'd0;
    p.reg_write_addr  = id_reg_write_addr;
    p.is_exception    = flags;
    p.exception_cause = cause;
    return p;
  endfunction

  function automatic wb_pkt_t observed();
    return '{pc: wb_pc, inst: wb_inst, result: wb_result, reg_write_en: wb_reg_write_en,
             reg_write_addr: wb_reg_write_addr, is_exception: wb_is_exception,
             exception_cause: wb_exception_cause};
  endfunction

  // Called at a falling edge: check outputs, update the scoreboard, advance one cycle.
  task automatic cycle();
    check("wb_valid", 128'(wb_valid), 128'(q.size() != 0));
    check("id_ready", 128'(id_ready), 128'(q.size() < DEPTH));
    check("retired_cnt", 128'(retired_cnt), 128'(exp_retired));
    if (wb_valid && q.size() != 0) check("head_pkt", 128'(observed()), 128'(q[0]));
    if (flush) begin
      q.delete();
    end else begin
      if (wb_valid && wb_ready && q.size() != 0) begin
        void'(q.pop_front());
        exp_retired++;
      end
      if (id_valid && id_ready) q.push_back(model());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic iv,
                       input logic [7:0] op, input logic [31:0] imm, input logic we,
                       input logic [4:0] rd, input logic [2:0] exc, input logic [20:0] cause);
    id_valid           = 1'b1;
    id_pc              = pc;
    id_inst            = inst;
    id_inst_valid      = iv;
    id_aluop           = op;
    id_imm             = imm;
    id_reg_write_en    = we;
    id_reg_write_addr  = rd;
    id_is_exception    = exc;
    id_exception_cause = cause;
  endtask

  task automatic idle();
    id_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    wb_ready = 1'b0;
    exp_retired = '0;
    drive(32'h0, 32'h0, 1'b0, ALU_NOP, 32'h0, 1'b0, 5'd0, 3'b000, 21'h0);
    idle();

    // Reset state
    #1;
    check("reset_wb_valid", 128'(wb_valid), 128'(0));
    check("reset_payload", 128'(observed()), 128'(0));
    check("reset_retired", 128'(retired_cnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("id_ready_after_reset", 128'(id_ready), 128'(1));
    @(negedge clk);

    // LU12I, streaming consumer
    wb_ready = 1'b1;
    drive(32'h1C00_0000, 32'h1424_6884, 1'b1, ALU_LU12I, 32'h1234_5000, 1'b1, 5'd4, 3'b000, 21'h0);
    cycle();
    idle();
    cycle();
    check("lu12i_retired_1", 128'(retired_cnt), 128'(1));
    cycle();

    // PCADDU12I with wrap, then a plain one back-to-back
    drive(32'hFFFF_F000, 32'h1C00_0025, 1'b1, ALU_PCADDU12I, 32'h0000_2000, 1'b1, 5'd5, 3'b000, 21'h0);
    cycle();
    check("pcadd_wrap_result", 128'(wb_result), 128'(32'h0000_1000));
    drive(32'h1C00_0004, 32'h1C00_0026, 1'b1, ALU_PCADDU12I, 32'h0000_1000, 1'b1, 5'd6, 3'b000, 21'h0);
    cycle();
    check("pcadd_result", 128'(wb_result), 128'(32'h1C00_1004));
    idle();
    cycle();
    cycle();

    // Backpressure: three bundles with the consumer stalled
    wb_ready = 1'b0;
    drive(32'h1C00_0100, 32'h1400_0021, 1'b1, ALU_LU12I, 32'hAAAA_A000, 1'b1, 5'd1, 3'b000, 21'h0);
    cycle();
    drive(32'h1C00_0104, 32'h1C00_0022, 1'b1, ALU_PCADDU12I, 32'h0001_0000, 1'b1, 5'd2, 3'b000, 21'h0);
    cycle();
    drive(32'h1C00_0108, 32'h1400_0023, 1'b1, ALU_LU12I, 32'h5555_5000, 1'b1, 5'd3, 3'b000, 21'h0);
    check("full_id_ready_low", 128'(id_ready), 128'(0));
    cycle();
    cycle();
    wb_ready = 1'b1;
    cycle();
    cycle();
    idle();
    cycle();
    cycle();

    // Illegal instruction, r0 suppression, upstream exception pass-through
    drive(32'h1C00_0200, 32'hFFFF_FFFF, 1'b0, ALU_NOP, 32'h0, 1'b0, 5'd7, 3'b000, 21'h0);
    cycle();
    check("ine_flags", 128'(wb_is_exception), 128'(3'b010));
    check("ine_cause_slot1", 128'(wb_exception_cause[13:7]), 128'(EXCEPTION_INE));
    drive(32'h1C00_0204, 32'h1400_0000, 1'b1, ALU_LU12I, 32'h0000_1000, 1'b1, 5'd0, 3'b000, 21'h0);
    cycle();
    check("r0_write_en", 128'(wb_reg_write_en), 128'(0));
    drive(32'h1C00_0208, 32'h1400_0008, 1'b0, ALU_LU12I, 32'h0000_3000, 1'b1, 5'd8, 3'b001, 21'h0_0041);
    cycle();
    idle();
    cycle();
    cycle();

    // Flush with a full FIFO while a push and a pop are both presented
    wb_ready = 1'b0;
    drive(32'h1C00_0300, 32'h1400_0031, 1'b1, ALU_LU12I, 32'h0003_1000, 1'b1, 5'd9, 3'b000, 21'h0);
    cycle();
    drive(32'h1C00_0304, 32'h1400_0032, 1'b1, ALU_LU12I, 32'h0003_2000, 1'b1, 5'd10, 3'b000, 21'h0);
    cycle();
    wb_ready = 1'b1;
    flush = 1'b1;
    drive(32'h1C00_0308, 32'h1400_0033, 1'b1, ALU_LU12I, 32'h0003_3000, 1'b1, 5'd11, 3'b000, 21'h0);
    cycle();
    flush = 1'b0;
    idle();
    check("post_flush_wb_valid", 128'(wb_valid), 128'(0));
    check("post_flush_id_ready", 128'(id_ready), 128'(1));
    cycle();

    // Asynchronous reset with one entry queued
    wb_ready = 1'b0;
    drive(32'h1C00_0400, 32'h1400_0041, 1'b1, ALU_LU12I, 32'h0004_1000, 1'b1, 5'd12, 3'b000, 21'h0);
    cycle();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_wb_valid", 128'(wb_valid), 128'(0));
    check("async_reset_retired", 128'(retired_cnt), 128'(0));
    q.delete();
    exp_retired = '0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_ready = 1'b1;
    drive(32'h1C00_0500, 32'h1400_0051, 1'b1, ALU_LU12I, 32'h0005_1000, 1'b1, 5'd13, 3'b000, 21'h0);
    cycle();
    idle();
    cycle();
    check("post_reset_retired", 128'(retired_cnt), 128'(1));
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
